pipe_ctrl: RTL and testbench

- Parametrised pipeline controller for the RV32 core.
- Owns the program counter, per-stage valid bits and pipeline-register load enables, load-use stall, branch/jump flush, operand-forwarding selects and a retired-instruction counter.
- A build-time mode selects either the current non-overlapped five-state sequencing (one instruction in flight) or full five-stage overlapped pipelining.
- Sits beside the datapath top; the datapath registers (IF/ID, ID/EX, EX/MEM, MEM/WB) load only when this block enables them.

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/hazard_unit.sv | 39 +++
 rtl/pipe_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32 pipeline controller: sequencer
// states, forwarding-select encodings, stage indices into the valid vector.
package pipe_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Bit positions inside the {wb, mem, ex, id} valid vector.
    localparam int V_ID   = 0;
    localparam int V_EX   = 1;
    localparam int V_MEM  = 2;
    localparam int V_WB   = 3;
    localparam int NSTAGE = 4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // The younger producer (MEM) is checked first so it shadows a stale WB value.
    function automatic logic [1:0] fwd_select(
        input logic       mem_wr,
        input logic       mem_v,
        input logic [4:0] mem_rd,
        input logic       wb_wr,
        input logic       wb_v,
        input logic [4:0] wb_rd,
        input logic [4:0] rs
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_wr && mem_v && (mem_rd != REG_ZERO) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_wr && wb_v && (wb_rd != REG_ZERO) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard logic for overlapped mode: load-use detection and
// ALU operand forwarding selects.
module hazard_unit
    import pipe_pkg::*;
(
    input  logic [NSTAGE-1:0] valid_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic              id_uses_rs1_i,
    input  logic              id_uses_rs2_i,
    input  logic [4:0]        ex_rs1_i,
    input  logic [4:0]        ex_rs2_i,
    input  logic [4:0]        ex_rd_i,
    input  logic              ex_is_load_i,
    input  logic [4:0]        mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [4:0]        wb_rd_i,
    input  logic              wb_wr_i,
    output logic              load_use_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

    // A load result only exists after MEM, so an ID consumer must wait one slot.
    assign load_use_o = valid_i[V_ID] && valid_i[V_EX] && ex_is_load_i &&
                        (ex_rd_i != REG_ZERO) && (rs1_hit || rs2_hit);

    assign fwd_a_o = fwd_select(mem_wr_i, valid_i[V_MEM], mem_rd_i,
                                wb_wr_i,  valid_i[V_WB],  wb_rd_i, ex_rs1_i);
    assign fwd_b_o = fwd_select(mem_wr_i, valid_i[V_MEM], mem_rd_i,
                                wb_wr_i,  valid_i[V_WB],  wb_rd_i, ex_rs2_i);

endmodule

// File: rtl/pipe_ctrl.sv
// RV32 pipeline controller: PC, stage valids, register load enables, hazard
// handling and retire counting, in either overlapped or one-at-a-time mode.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter bit              PIPELINED = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [4:0]        ex_rs1,
    input  logic [4:0]        ex_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_redirect,
    input  logic [XLEN-1:0]   ex_target,
    input  logic [4:0]        mem_rd,
    input  logic [4:0]        wb_rd,
    input  logic              mem_wr,
    input  logic              wb_wr,
    output logic [XLEN-1:0]   pc,
    output logic              en_if_id,
    output logic              en_id_ex,
    output logic              en_ex_mem,
    output logic              en_mem_wb,
    output logic [NSTAGE-1:0] valid,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              retire,
    output logic [XLEN-1:0]   instret,
    output logic [2:0]        state
);

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instret_q, instret_d;
    logic [XLEN-1:0]   tgt_q, tgt_d;
    logic              redir_q, redir_d;
    logic [NSTAGE-1:0] valid_q, valid_d;
    state_e            state_q, state_d;

    logic              load_use;
    logic              redirect;
    logic              retire_c;
    logic [1:0]        fwd_a_c, fwd_b_c;
    logic              en_if_id_c, en_id_ex_c, en_ex_mem_c, en_mem_wb_c;
    logic [XLEN-1:0]   ex_target_al;

    assign ex_target_al = ex_target & ALIGN_MASK;
    assign redirect     = ex_redirect && valid_q[V_EX];

    generate
        if (PIPELINED) begin : g_hazard
            hazard_unit u_hazard (
                .valid_i       (valid_q),
                .id_rs1_i      (id_rs1),
                .id_rs2_i      (id_rs2),
                .id_uses_rs1_i (id_uses_rs1),
                .id_uses_rs2_i (id_uses_rs2),
                .ex_rs1_i      (ex_rs1),
                .ex_rs2_i      (ex_rs2),
                .ex_rd_i       (ex_rd),
                .ex_is_load_i  (ex_is_load),
                .mem_rd_i      (mem_rd),
                .mem_wr_i      (mem_wr),
                .wb_rd_i       (wb_rd),
                .wb_wr_i       (wb_wr),
                .load_use_o    (load_use),
                .fwd_a_o       (fwd_a_c),
                .fwd_b_o       (fwd_b_c)
            );
        end else begin : g_no_hazard
            assign load_use = 1'b0;
            assign fwd_a_c  = FWD_RF;
            assign fwd_b_c  = FWD_RF;
        end
    endgenerate

    assign retire_c  = !hold && (PIPELINED ? valid_q[V_WB] : (state_q == WRITEBACK));
    assign instret_d = instret_q + XLEN'(retire_c);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        pc_d        = pc_q;
        valid_d     = valid_q;
        state_d     = state_q;
        redir_d     = redir_q;
        tgt_d       = tgt_q;
        en_if_id_c  = 1'b0;
        en_id_ex_c  = 1'b0;
        en_ex_mem_c = 1'b0;
        en_mem_wb_c = 1'b0;

        if (PIPELINED) begin
            state_d = FETCH;
            if (!hold) begin
                en_id_ex_c  = 1'b1;
                en_ex_mem_c = 1'b1;
                en_mem_wb_c = 1'b1;
                // Redirect is checked first: a stalled ID instruction is squashed anyway.
                if (redirect) begin
                    en_if_id_c = 1'b1;
                    pc_d       = ex_target_al;
                    valid_d    = {valid_q[V_MEM], valid_q[V_EX], 1'b0, 1'b0};
                end else if (load_use) begin
                    valid_d    = {valid_q[V_MEM], valid_q[V_EX], 1'b0, valid_q[V_ID]};
                end else begin
                    en_if_id_c = 1'b1;
                    pc_d       = pc_q + PC_STEP;
                    valid_d    = {valid_q[V_MEM], valid_q[V_EX], valid_q[V_ID], 1'b1};
                end
            end
        end else if (!hold) begin
            unique case (state_q)
                FETCH: begin
                    state_d = DECODE;
                    valid_d = 4'b0001;
                end
                DECODE: begin
                    en_if_id_c = 1'b1;
                    state_d    = EXECUTE;
                    valid_d    = 4'b0010;
                end
                EXECUTE: begin
                    en_id_ex_c = 1'b1;
                    redir_d    = ex_redirect;
                    tgt_d      = ex_target_al;
                    state_d    = MEMORY;
                    valid_d    = 4'b0100;
                end
                MEMORY: begin
                    en_ex_mem_c = 1'b1;
                    state_d     = WRITEBACK;
                    valid_d     = 4'b1000;
                end
                WRITEBACK: begin
                    en_mem_wb_c = 1'b1;
                    pc_d        = redir_q ? tgt_q : (pc_q + PC_STEP);
                    redir_d     = 1'b0;
                    state_d     = FETCH;
                    valid_d     = '0;
                end
                default: begin
                    state_d = FETCH;
                    valid_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
        if (!reset) begin
            pc_q      <= RESET_PC;
            valid_q   <= '0;
            instret_q <= '0;
            state_q   <= FETCH;
            redir_q   <= 1'b0;
            tgt_q     <= '0;
        end else begin
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            instret_q <= instret_d;
            state_q   <= state_d;
            redir_q   <= redir_d;
            tgt_q     <= tgt_d;
        end
    end

    assign pc        = pc_q;
    assign valid     = valid_q;
    assign instret   = instret_q;
    assign state     = state_q;
    assign retire    = retire_c;
    assign fwd_a     = fwd_a_c;
    assign fwd_b     = fwd_b_c;
    assign en_if_id  = en_if_id_c;
    assign en_id_ex  = en_id_ex_c;
    assign en_ex_mem = en_ex_mem_c;
    assign en_mem_wb = en_mem_wb_c;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: an overlapped instance (RESET_PC=0x100) and a sequential
// instance (RESET_PC=0) share stimulus; per-cycle expectations go through a queue.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset, hold;
    logic [4:0]      id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic            id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect, mem_wr, wb_wr;
    logic [XLEN-1:0] ex_target;

    logic [XLEN-1:0] p_pc, p_instret, s_pc, s_instret;
    logic            p_en_if_id, p_en_id_ex, p_en_ex_mem, p_en_mem_wb, p_retire;
    logic            s_en_if_id, s_en_id_ex, s_en_ex_mem, s_en_mem_wb, s_retire;
    logic [3:0]      p_valid, s_valid;
    logic [1:0]      p_fwd_a, p_fwd_b, s_fwd_a, s_fwd_b;
    logic [2:0]      p_state, s_state;

    int total = 0;
    int bad   = 0;
    int test_id = 0;

    typedef struct {
        bit         seq;
        int         tid;
        int         cyc;
        logic [31:0] pc;
        logic [3:0]  valid;
        logic [31:0] instret;
        logic        retire;
        logic [2:0]  state;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    pipe_ctrl #(.XLEN(XLEN), .RESET_PC(32'h100), .PIPELINED(1'b1)) u_pipe (
        .clk(clk), .reset(reset), .hold(hold),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_wr(mem_wr), .wb_wr(wb_wr),
        .pc(p_pc), .en_if_id(p_en_if_id), .en_id_ex(p_en_id_ex), .en_ex_mem(p_en_ex_mem),
        .en_mem_wb(p_en_mem_wb), .valid(p_valid), .fwd_a(p_fwd_a), .fwd_b(p_fwd_b),
        .retire(p_retire), .instret(p_instret), .state(p_state)
    );

    pipe_ctrl #(.XLEN(XLEN), .RESET_PC(32'h0), .PIPELINED(1'b0)) u_seq (
        .clk(clk), .reset(reset), .hold(hold),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_wr(mem_wr), .wb_wr(wb_wr),
        .pc(s_pc), .en_if_id(s_en_if_id), .en_id_ex(s_en_id_ex), .en_ex_mem(s_en_ex_mem),
        .en_mem_wb(s_en_mem_wb), .valid(s_valid), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .retire(s_retire), .instret(s_instret), .state(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: everything pushed for the current cycle is checked at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            total += 5;
            if (mon_e.seq) begin
                if (s_pc !== mon_e.pc) begin bad++; $display("FAIL seq_pc t=%0d c=%0d got=%h exp=%h", mon_e.tid, mon_e.cyc, s_pc, mon_e.pc); end
                if (s_valid !== mon_e.valid) begin bad++; $display("FAIL seq_valid t=%0d c=%0d got=%b exp=%b", mon_e.tid, mon_e.cyc, s_valid, mon_e.valid); end
                if (s_instret !== mon_e.instret) begin bad++; $display("FAIL seq_instret t=%0d c=%0d got=%0d exp=%0d", mon_e.tid, mon_e.cyc, s_instret, mon_e.instret); end
                if (s_retire !== mon_e.retire) begin bad++; $display("FAIL seq_retire t=%0d c=%0d got=%b exp=%b", mon_e.tid, mon_e.cyc, s_retire, mon_e.retire); end
                if (s_state !== mon_e.state) begin bad++; $display("FAIL seq_state t=%0d c=%0d got=%0d exp=%0d", mon_e.tid, mon_e.cyc, s_state, mon_e.state); end
            end else begin
                if (p_pc !== mon_e.pc) begin bad++; $display("FAIL pipe_pc t=%0d c=%0d got=%h exp=%h", mon_e.tid, mon_e.cyc, p_pc, mon_e.pc); end
                if (p_valid !== mon_e.valid) begin bad++; $display("FAIL pipe_valid t=%0d c=%0d got=%b exp=%b", mon_e.tid, mon_e.cyc, p_valid, mon_e.valid); end
                if (p_instret !== mon_e.instret) begin bad++; $display("FAIL pipe_instret t=%0d c=%0d got=%0d exp=%0d", mon_e.tid, mon_e.cyc, p_instret, mon_e.instret); end
                if (p_retire !== mon_e.retire) begin bad++; $display("FAIL pipe_retire t=%0d c=%0d got=%b exp=%b", mon_e.tid, mon_e.cyc, p_retire, mon_e.retire); end
                if (p_state !== mon_e.state) begin bad++; $display("FAIL pipe_state t=%0d c=%0d got=%0d exp=%0d", mon_e.tid, mon_e.cyc, p_state, mon_e.state); end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_p(input int cyc, input logic [31:0] pc_e, input logic [3:0] v_e,
                          input logic [31:0] ir_e, input logic rt_e);
        exp_t e;
        e.seq = 1'b0; e.tid = test_id; e.cyc = cyc; e.pc = pc_e; e.valid = v_e;
        e.instret = ir_e; e.retire = rt_e; e.state = 3'd0;
        sb.push_back(e);
    endtask

    task automatic push_s(input int cyc, input logic [31:0] pc_e, input logic [3:0] v_e,
                          input logic [31:0] ir_e, input logic rt_e, input logic [2:0] st_e);
        exp_t e;
        e.seq = 1'b1; e.tid = test_id; e.cyc = cyc; e.pc = pc_e; e.valid = v_e;
        e.instret = ir_e; e.retire = rt_e; e.state = st_e;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        hold = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_is_load = 1'b0; ex_redirect = 1'b0;
        ex_target = '0; mem_rd = '0; wb_rd = '0; mem_wr = 1'b0; wb_wr = 1'b0;
    endtask

    // Returns in cycle 0: reset has just been released, the next edge is the first run edge.
    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    function automatic logic [3:0] fill_valid(input int c);
        logic [3:0] v;
        case (c)
            0: v = 4'b0000;
            1: v = 4'b0001;
            2: v = 4'b0011;
            3: v = 4'b0111;
            default: v = 4'b1111;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        test_id = 1;
        reset = 1'b0;
        clear_inputs();
        tick();
        tick();
        push_p(-1, 32'h100, 4'b0000, 32'd0, 1'b0);
        push_s(-1, 32'h0, 4'b0000, 32'd0, 1'b0, 3'd0);
        total++;
        if (p_en_if_id !== 1'b1) begin bad++; $display("FAIL reset_en_if_id got=%b exp=1", p_en_if_id); end
        tick();
    endtask

    task automatic test_straight_line();
        test_id = 2;
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) tick();
            push_p(c, 32'h100 + 32'(4 * c), fill_valid(c), (c >= 5) ? 32'(c - 4) : 32'd0, (c >= 4));
            total++;
            if ({p_en_if_id, p_en_id_ex, p_en_ex_mem, p_en_mem_wb} !== 4'b1111) begin
                bad++; $display("FAIL straight_en c=%0d got=%b exp=1111", c,
                                {p_en_if_id, p_en_id_ex, p_en_ex_mem, p_en_mem_wb});
            end
        end
        tick();
    endtask

    task automatic test_load_use();
        test_id = 3;
        do_reset();
        tick();
        tick();
        // cycle 2: near-miss hazards must not stall
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        #1;
        total++;
        if (p_en_if_id !== 1'b1) begin bad++; $display("FAIL lu_rd_zero got=%b exp=1", p_en_if_id); end
        ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b0;
        #1;
        total++;
        if (p_en_if_id !== 1'b1) begin bad++; $display("FAIL lu_unused_src got=%b exp=1", p_en_if_id); end
        tick();
        // cycle 3: rs2 match stalls, then the rs1 case is taken into the edge
        id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        #1;
        total++;
        if (p_en_if_id !== 1'b0) begin bad++; $display("FAIL lu_rs2 got=%b exp=0", p_en_if_id); end
        id_rs2 = 5'd0; id_uses_rs2 = 1'b0; id_uses_rs1 = 1'b1;
        #1;
        total++;
        if ({p_en_if_id, p_en_id_ex, p_en_ex_mem, p_en_mem_wb} !== 4'b0111) begin
            bad++; $display("FAIL lu_enables got=%b exp=0111",
                            {p_en_if_id, p_en_id_ex, p_en_ex_mem, p_en_mem_wb});
        end
        push_p(3, 32'h10C, 4'b0111, 32'd0, 1'b0);
        tick();
        clear_inputs();
        push_p(4, 32'h10C, 4'b1101, 32'd0, 1'b1);
        tick();
        push_p(5, 32'h110, 4'b1011, 32'd1, 1'b1);
        tick();
        push_p(6, 32'h114, 4'b0111, 32'd2, 1'b0);
        tick();
    endtask

    task automatic test_redirect();
        test_id = 4;
        do_reset();
        tick();
        ex_redirect = 1'b1; ex_target = 32'h2003;   // EX not yet valid: ignored
        push_p(1, 32'h104, 4'b0001, 32'd0, 1'b0);
        tick();
        ex_redirect = 1'b0;
        push_p(2, 32'h108, 4'b0011, 32'd0, 1'b0);
        tick();
        ex_redirect = 1'b1;
        push_p(3, 32'h10C, 4'b0111, 32'd0, 1'b0);
        tick();
        ex_redirect = 1'b0;
        push_p(4, 32'h2000, 4'b1100, 32'd0, 1'b1);
        tick();
        push_p(5, 32'h2004, 4'b1001, 32'd1, 1'b1);
        tick();
        push_p(6, 32'h2008, 4'b0011, 32'd2, 1'b0);
        tick();
        push_p(7, 32'h200C, 4'b0111, 32'd2, 1'b0);
        tick();

        test_id = 5;
        do_reset();
        tick(); tick(); tick();
        ex_redirect = 1'b1; ex_target = 32'h2003;
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        push_p(3, 32'h10C, 4'b0111, 32'd0, 1'b0);
        tick();
        clear_inputs();
        total++;
        if (p_pc !== 32'h2000) begin bad++; $display("FAIL redir_stall_pc got=%h exp=00002000", p_pc); end
        push_p(4, 32'h2000, 4'b1100, 32'd0, 1'b1);
        tick();
        push_p(5, 32'h2004, 4'b1001, 32'd1, 1'b1);
        tick();

        test_id = 6;
        do_reset();
        tick(); tick(); tick();
        ex_redirect = 1'b1; ex_target = 32'hFFFF_FFFF;
        tick();
        ex_redirect = 1'b0;
        push_p(4, 32'hFFFF_FFFC, 4'b1100, 32'd0, 1'b1);
        tick();
        push_p(5, 32'h0000_0000, 4'b1001, 32'd1, 1'b1);
        tick();
    endtask

    task automatic test_forwarding();
        test_id = 7;
        do_reset();
        tick(); tick(); tick(); tick();
        mem_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7; ex_rs2 = 5'd7; mem_wr = 1'b1; wb_wr = 1'b1;
        #1;
        total += 3;
        if (p_fwd_a !== FWD_MEM) begin bad++; $display("FAIL fwd_a_mem got=%b exp=01", p_fwd_a); end
        if (p_fwd_b !== FWD_MEM) begin bad++; $display("FAIL fwd_b_mem got=%b exp=01", p_fwd_b); end
        if (s_fwd_a !== FWD_RF) begin bad++; $display("FAIL seq_fwd_a got=%b exp=00", s_fwd_a); end
        mem_rd = 5'd0;
        #1;
        total += 2;
        if (p_fwd_a !== FWD_WB) begin bad++; $display("FAIL fwd_a_wb got=%b exp=10", p_fwd_a); end
        if (p_fwd_b !== FWD_WB) begin bad++; $display("FAIL fwd_b_wb got=%b exp=10", p_fwd_b); end
        wb_wr = 1'b0;
        #1;
        total++;
        if (p_fwd_a !== FWD_RF) begin bad++; $display("FAIL fwd_a_rf got=%b exp=00", p_fwd_a); end
        tick();
        mem_rd = 5'd3; mem_wr = 1'b1; ex_rs2 = 5'd3; ex_rs1 = 5'd7; wb_rd = 5'd7; wb_wr = 1'b1;
        #1;
        total += 2;
        if (p_fwd_a !== FWD_WB) begin bad++; $display("FAIL fwd_a_split got=%b exp=10", p_fwd_a); end
        if (p_fwd_b !== FWD_MEM) begin bad++; $display("FAIL fwd_b_split got=%b exp=01", p_fwd_b); end
        clear_inputs();
        tick();
    endtask

    task automatic test_hold_and_reset();
        test_id = 8;
        do_reset();
        tick(); tick(); tick(); tick();
        hold = 1'b1; ex_redirect = 1'b1; ex_target = 32'h3000;
        #1;
        total++;
        if ({p_en_if_id, p_en_id_ex, p_en_ex_mem, p_en_mem_wb} !== 4'b0000) begin
            bad++; $display("FAIL hold_en got=%b exp=0000",
                            {p_en_if_id, p_en_id_ex, p_en_ex_mem, p_en_mem_wb});
        end
        push_p(4, 32'h110, 4'b1111, 32'd0, 1'b0);
        for (int c = 5; c <= 6; c++) begin
            tick();
            push_p(c, 32'h110, 4'b1111, 32'd0, 1'b0);
        end
        tick();
        hold = 1'b0;
        push_p(7, 32'h110, 4'b1111, 32'd0, 1'b1);
        tick();
        ex_redirect = 1'b0;
        push_p(8, 32'h3000, 4'b1100, 32'd1, 1'b1);
        reset = 1'b0;
        tick();
        push_p(9, 32'h100, 4'b0000, 32'd0, 1'b0);
        total++;
        if (p_instret !== 32'd0) begin bad++; $display("FAIL midreset_instret got=%0d exp=0", p_instret); end
        tick();
    endtask

    task automatic test_sequential();
        int st;
        logic [31:0] pc_e;
        test_id = 9;
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            if (c > 0) tick();
            ex_redirect = (c == 7) || (c == 8);
            ex_target   = (c == 8) ? 32'h80 : 32'h40;
            st   = c % 5;
            pc_e = (c < 10) ? 32'(4 * (c / 5)) : ((c < 15) ? 32'h40 : 32'h44);
            push_s(c, pc_e, (st == 0) ? 4'b0000 : 4'(1 << (st - 1)), 32'(c / 5), (st == 4), 3'(st));
            #1;
            total++;
            if ({s_en_mem_wb, s_en_ex_mem, s_en_id_ex, s_en_if_id} !==
                ((st == 0) ? 4'b0000 : 4'(1 << (st - 1)))) begin
                bad++; $display("FAIL seq_en c=%0d got=%b st=%0d",
                                c, {s_en_mem_wb, s_en_ex_mem, s_en_id_ex, s_en_if_id}, st);
            end
        end
        ex_redirect = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_straight_line();
        test_load_use();
        test_redirect();
        test_forwarding();
        test_hold_and_reset();
        test_sequential();
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL sb_drain left=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
